// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD block family: default datapath width,
// the client FSM state type and a small constant helper.
package gcd_pkg;

    localparam int GCD_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        RUN,
        RESP
    } gcd_client_state_t;

    function automatic int gcd_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gcd_client_if.sv
// Request/response channel between the system bus glue (master) and the
// GCD client (slave).
interface gcd_client_if import gcd_pkg::*; #(
    parameter int W = GCD_W
);
    // Both channels are valid/ready: a transfer happens on the rising edge where
    // valid and ready are both high; the sender keeps valid and its payload stable
    // until then, and ready may depend on nothing the sender drives.
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_x;
    logic [W-1:0] req_y;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_gcd;
    logic         rsp_err;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_gcd, rsp_err
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_gcd, rsp_err
    );

endinterface

// File: rtl/gcd_cycle_counter.sv
// Up-counter with synchronous clear and enable; tc flags that the current
// count equals the supplied terminal value.
module gcd_cycle_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] term,
    output logic          tc
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == term);

endmodule

// File: rtl/gcd_client.sv
// Initiator for the GCD core go/clear handshake: takes operand pairs, sequences
// clr/go on the core with a timeout, and returns the result on a response channel.
module gcd_client import gcd_pkg::*; #(
    parameter int W          = GCD_W,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 300
) (
    input  logic              clk,
    input  logic              clr_n,
    gcd_client_if.slave       bus,
    output logic              core_clr,
    output logic              core_go,
    output logic [W-1:0]      core_x,
    output logic [W-1:0]      core_y,
    input  logic [W-1:0]      core_gcd,
    input  logic              core_done,
    output gcd_client_state_t dbg_state
);

    localparam int CW = $clog2(gcd_max(TIMEOUT, CLR_CYCLES) + 1);
    // The counter sits at 0 in the first cycle of CLEAR/RUN, so the last cycle sees N-1.
    localparam logic [CW-1:0] CLR_TERM = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] TMO_TERM = CW'(TIMEOUT - 1);

    gcd_client_state_t state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [W-1:0]      rsp_gcd_q, rsp_gcd_d;
    logic              rsp_err_q, rsp_err_d;
    logic              core_clr_q, core_clr_d;
    logic              core_go_q, core_go_d;
    logic [W-1:0]      core_x_q, core_x_d;
    logic [W-1:0]      core_y_q, core_y_d;

    logic              cnt_clr;
    logic              cnt_en;
    logic [CW-1:0]     cnt_term;
    logic              cnt_tc;

    gcd_cycle_counter #(.CW(CW)) u_cnt (
        .clk   (clk),
        .rst_n (clr_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .term  (cnt_term),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_gcd_d   = rsp_gcd_q;
        rsp_err_d   = rsp_err_q;
        core_clr_d  = core_clr_q;
        core_go_d   = core_go_q;
        core_x_d    = core_x_q;
        core_y_d    = core_y_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        cnt_term    = TMO_TERM;

        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    core_x_d    = bus.req_x;
                    core_y_d    = bus.req_y;
                    req_ready_d = 1'b0;
                    // A zero operand makes the answer the other operand; skip the core.
                    if ((bus.req_x == '0) || (bus.req_y == '0)) begin
                        rsp_gcd_d   = bus.req_x | bus.req_y;
                        rsp_err_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        core_clr_d = 1'b1;
                        state_d    = CLEAR;
                    end
                end
            end
            CLEAR: begin
                cnt_en   = 1'b1;
                cnt_term = CLR_TERM;
                if (cnt_tc) begin
                    core_clr_d = 1'b0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                cnt_clr   = 1'b1;
                core_go_d = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                cnt_en = 1'b1;
                // done has priority over a timeout landing in the same cycle.
                if (core_done) begin
                    rsp_gcd_d   = core_gcd;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_tc) begin
                    rsp_gcd_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    core_go_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_gcd_q   <= '0;
            rsp_err_q   <= 1'b0;
            core_clr_q  <= 1'b0;
            core_go_q   <= 1'b0;
            core_x_q    <= '0;
            core_y_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_gcd_q   <= rsp_gcd_d;
            rsp_err_q   <= rsp_err_d;
            core_clr_q  <= core_clr_d;
            core_go_q   <= core_go_d;
            core_x_q    <= core_x_d;
            core_y_q    <= core_y_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_gcd   = rsp_gcd_q;
    assign bus.rsp_err   = rsp_err_q;
    assign core_clr      = core_clr_q;
    assign core_go       = core_go_q;
    assign core_x        = core_x_q;
    assign core_y        = core_y_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_gcd_client.sv
// Directed bench for gcd_client: vector table for single requests plus hand-written
// sequences for back-to-back, timeout, backpressure and mid-run reset.
module tb_gcd_client;
  import gcd_pkg::*;

  localparam int W   = 8;
  localparam int CLR = 2;
  localparam int TMO = 300;
  localparam int NEVER = 100000;

  // clock / reset
  logic clk = 1'b0;
  logic clr_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gcd_client_if #(.W(W)) bus ();
  logic              core_clr;
  logic              core_go;
  logic [W-1:0]      core_x;
  logic [W-1:0]      core_y;
  logic [W-1:0]      core_gcd;
  logic              core_done;
  gcd_client_state_t dbg_state;

  gcd_client #(.W(W), .CLR_CYCLES(CLR), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .bus       (bus),
    .core_clr  (core_clr),
    .core_go   (core_go),
    .core_x    (core_x),
    .core_y    (core_y),
    .core_gcd  (core_gcd),
    .core_done (core_done),
    .dbg_state (dbg_state)
  );

  // behavioural core: done rises in RUN cycle done_at and stays up while go is high
  int done_at = 3;
  int go_cnt = 0;
  always @(posedge clk) go_cnt <= core_go ? go_cnt + 1 : 0;
  assign core_done = core_go && (go_cnt >= done_at - 1);

  function automatic logic [W-1:0] euclid(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != '0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  always_comb begin
    core_gcd = '0;
    if (core_done) core_gcd = euclid(core_x, core_y);
  end

  // activity monitors, sampled on the falling edge
  int clr_hi = 0;
  int go_hi = 0;
  int go_rise = -1;
  int hs_cnt = 0;
  logic go_prev = 1'b0;
  always @(negedge clk) begin
    if (core_clr) clr_hi++;
    if (core_go) go_hi++;
    if (core_go && !go_prev && go_rise < 0) go_rise = cyc;
    go_prev = core_go;
    if (bus.rsp_valid && bus.rsp_ready) hs_cnt++;
  end

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_mon();
    clr_hi = 0;
    go_hi = 0;
    go_rise = -1;
  endtask

  // driver tasks; all are entered and left 1 time unit after a rising edge
  task automatic send_req(input logic [W-1:0] x, input logic [W-1:0] y, output int acc);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_x = x;
    bus.req_y = y;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_wait", int'(bus.req_ready), 1);
    @(posedge clk); #1;
    acc = cyc;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int at);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_valid_wait", int'(bus.rsp_valid), 1);
    at = cyc;
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] gcd;
    int           lat;     // rsp_valid cycle minus first cycle after accept
    int           clr;     // cycles with core_clr high
    int           go_off;  // core_go rise relative to first cycle after accept, -1 = never
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a, a2, r, r2, n, hs0, seen;

    // latency for a core answering in RUN cycle 3: CLR + 3 + 1
    vecs[0] = '{8'd228, 8'd52,  8'd4,   6, 2,  3};
    vecs[1] = '{8'd52,  8'd52,  8'd52,  6, 2,  3};
    vecs[2] = '{8'd45,  8'd139, 8'd1,   6, 2,  3};
    vecs[3] = '{8'd255, 8'd17,  8'd17,  6, 2,  3};
    vecs[4] = '{8'd96,  8'd36,  8'd12,  6, 2,  3};
    vecs[5] = '{8'd1,   8'd200, 8'd1,   6, 2,  3};
    vecs[6] = '{8'd0,   8'd37,  8'd37,  0, 0, -1};
    vecs[7] = '{8'd37,  8'd0,   8'd37,  0, 0, -1};
    vecs[8] = '{8'd0,   8'd0,   8'd0,   0, 0, -1};

    bus.req_valid = 1'b0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.rsp_ready = 1'b0;

    #1 clr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", int'(bus.req_ready), 1);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_gcd",   int'(bus.rsp_gcd), 0);
    chk("rst_rsp_err",   int'(bus.rsp_err), 0);
    chk("rst_core_clr",  int'(core_clr), 0);
    chk("rst_core_go",   int'(core_go), 0);
    chk("rst_core_x",    int'(core_x), 0);
    chk("rst_core_y",    int'(core_y), 0);
    chk("rst_state",     int'(dbg_state), int'(IDLE));
    clr_n = 1'b1;
    @(posedge clk); #1;

    // table-driven single requests
    for (int i = 0; i < 9; i++) begin
      done_at = 3;
      clear_mon();
      send_req(vecs[i].x, vecs[i].y, a);
      chk("tbl_x_latch", int'(core_x), int'(vecs[i].x));
      chk("tbl_y_latch", int'(core_y), int'(vecs[i].y));
      wait_rsp(50, r);
      chk("tbl_gcd", int'(bus.rsp_gcd), int'(vecs[i].gcd));
      chk("tbl_err", int'(bus.rsp_err), 0);
      chk("tbl_latency", r - a, vecs[i].lat);
      chk("tbl_clr_cycles", clr_hi, vecs[i].clr);
      chk("tbl_go_rise", (go_rise < 0) ? -1 : go_rise - a, vecs[i].go_off);
      finish_rsp();
      chk("tbl_idle_ready", int'(bus.req_ready), 1);
      chk("tbl_go_dropped", int'(core_go), 0);
      chk("tbl_x_stable", int'(core_x), int'(vecs[i].x));
    end

    // back-to-back with rsp_ready tied high
    done_at = 3;
    bus.rsp_ready = 1'b1;
    send_req(8'd52, 8'd52, a);
    wait_rsp(50, r);
    chk("b2b_gcd1", int'(bus.rsp_gcd), 52);
    chk("b2b_lat1", r - a, 6);
    bus.req_valid = 1'b1;
    bus.req_x = 8'd45;
    bus.req_y = 8'd139;
    @(posedge clk); #1;
    chk("b2b_idle_ready", int'(bus.req_ready), 1);
    chk("b2b_idle_valid", int'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    a2 = cyc;
    bus.req_valid = 1'b0;
    chk("b2b_accepted", int'(bus.req_ready), 0);
    chk("b2b_x_latch", int'(core_x), 45);
    chk("b2b_gap", a2 - r, 2);
    wait_rsp(50, r2);
    chk("b2b_gcd2", int'(bus.rsp_gcd), 1);
    chk("b2b_lat2", r2 - a2, 6);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("b2b_back_idle", int'(dbg_state), int'(IDLE));

    // core never answers: timeout after TMO RUN cycles
    done_at = NEVER;
    send_req(8'd228, 8'd52, a);
    wait_rsp(400, r);
    chk("tmo_err", int'(bus.rsp_err), 1);
    chk("tmo_gcd", int'(bus.rsp_gcd), 0);
    chk("tmo_latency", r - a, CLR + TMO + 1);
    chk("tmo_go_held", int'(core_go), 1);
    finish_rsp();

    // done arrives in the very RUN cycle the timeout would fire
    done_at = TMO;
    send_req(8'd228, 8'd52, a);
    wait_rsp(400, r);
    chk("edge_err", int'(bus.rsp_err), 0);
    chk("edge_gcd", int'(bus.rsp_gcd), 4);
    chk("edge_latency", r - a, CLR + TMO + 1);
    finish_rsp();

    // backpressure: hold rsp_ready low, offer a competing request
    done_at = 3;
    send_req(8'd228, 8'd52, a);
    wait_rsp(50, r);
    bus.req_valid = 1'b1;
    bus.req_x = 8'd9;
    bus.req_y = 8'd3;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", int'(bus.rsp_valid), 1);
      chk("bp_gcd", int'(bus.rsp_gcd), 4);
      chk("bp_go", int'(core_go), 1);
      chk("bp_req_ready", int'(bus.req_ready), 0);
      chk("bp_x_hold", int'(core_x), 228);
    end
    bus.req_valid = 1'b0;
    finish_rsp();
    chk("bp_release_ready", int'(bus.req_ready), 1);
    chk("bp_not_accepted", int'(core_y), 52);

    // reset pulsed in RUN: immediate reset values, no response
    done_at = 50;
    hs0 = hs_cnt;
    send_req(8'd228, 8'd52, a);
    n = 0;
    while (!core_go && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_mid_go_seen", int'(core_go), 1);
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_in_run", int'(dbg_state), int'(RUN));
    #2 clr_n = 1'b0;
    #1;
    chk("arst_req_ready", int'(bus.req_ready), 1);
    chk("arst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("arst_rsp_gcd",   int'(bus.rsp_gcd), 0);
    chk("arst_rsp_err",   int'(bus.rsp_err), 0);
    chk("arst_core_clr",  int'(core_clr), 0);
    chk("arst_core_go",   int'(core_go), 0);
    chk("arst_core_x",    int'(core_x), 0);
    chk("arst_core_y",    int'(core_y), 0);
    chk("arst_state",     int'(dbg_state), int'(IDLE));
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    bus.rsp_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen++;
    end
    bus.rsp_ready = 1'b0;
    chk("arst_no_rsp", seen, 0);
    chk("arst_no_handshake", hs_cnt - hs0, 0);

    done_at = 3;
    send_req(8'd228, 8'd52, a);
    wait_rsp(50, r);
    chk("post_rst_gcd", int'(bus.rsp_gcd), 4);
    chk("post_rst_err", int'(bus.rsp_err), 0);
    chk("post_rst_lat", r - a, 6);
    finish_rsp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
